// File: rtl/ez8_alu.sv
// ez8_alu: 8-bit ALU for the ez8 datapath (GET/PUT, shift, add/sub, logic, SET, CLR/COM).
// Ports: clk/reset (async active-high); opcode/selector/direction decode; operand, regvalue,
//        accum, cin data in; result, accum_write, reg_write, z_write/zout, c_write/cout out.
// Latency: one clk; all outputs registered, no backpressure (accepts a new op every cycle).
module ez8_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [7:0] operand,
  input  logic [7:0] regvalue,
  input  logic [7:0] accum,
  input  logic [2:0] selector,
  input  logic       direction,
  input  logic       cin,
  output logic [7:0] result,
  output logic       accum_write,
  output logic       reg_write,
  output logic       z_write,
  output logic       zout,
  output logic       c_write,
  output logic       cout
);

  logic [7:0] result_d, result_q;
  logic       accum_write_d, accum_write_q;
  logic       reg_write_d, reg_write_q;
  logic       z_write_d, z_write_q;
  logic       zout_d, zout_q;
  logic       c_write_d, c_write_q;
  logic       cout_d, cout_q;

  logic [7:0] src_b;
  logic [8:0] sum;
  logic [2:0] shamt;

  // opcode[2] picks the literal over the register-file value for every class that uses B.
  assign src_b = opcode[2] ? operand : regvalue;
  assign shamt = src_b[2:0];

  always_comb begin
    result_d      = 8'h00;
    accum_write_d = 1'b0;
    reg_write_d   = 1'b0;
    z_write_d     = 1'b0;
    c_write_d     = 1'b0;
    cout_d        = 1'b0;
    sum           = 9'h000;

    // Class is carried in opcode[1:0]; opcode[2] is the literal flag, so 0x01 and 1x01 etc.
    // all decode to the same class. 0000/0100 and 1111 are the special cases.
    case (opcode[1:0])
      2'b00: begin
        if (opcode == 4'b0000) begin
          // GET pulls the register into the accumulator, PUT pushes the accumulator out.
          result_d      = direction ? accum : regvalue;
          accum_write_d = ~direction;
          reg_write_d   = direction;
        end else if (opcode == 4'b0100) begin
          result_d      = operand;
          accum_write_d = ~direction;
          reg_write_d   = direction;
        end
      end

      2'b01: begin
        accum_write_d = ~direction;
        reg_write_d   = direction;
        z_write_d     = 1'b1;
        case (selector)
          3'b100:  result_d = accum >> shamt;
          3'b110:  result_d = 8'($signed(accum) >>> shamt);
          default: result_d = accum << shamt;
        endcase
      end

      2'b10: begin
        accum_write_d = ~direction;
        reg_write_d   = direction;
        z_write_d     = 1'b1;
        c_write_d     = 1'b1;
        // Subtraction is add-of-complement, so carry out = 1 means no borrow.
        case (selector)
          3'b010:  sum = {1'b0, accum} + {1'b0, src_b} + {8'h00, cin};
          3'b100:  sum = {1'b0, accum} + {1'b0, ~src_b} + 9'd1;
          3'b110:  sum = {1'b0, accum} + {1'b0, ~src_b} + {8'h00, cin};
          default: sum = {1'b0, accum} + {1'b0, src_b};
        endcase
        result_d = sum[7:0];
        cout_d   = sum[8];
      end

      default: begin
        accum_write_d = ~direction;
        reg_write_d   = direction;
        z_write_d     = 1'b1;
        if (opcode == 4'b1111) begin
          // CLR / COM share the logic class encoding with the literal flag set.
          result_d = (selector == 3'b100) ? ~regvalue : 8'h00;
        end else begin
          case (selector)
            3'b010:  result_d = accum | src_b;
            3'b100:  result_d = accum ^ src_b;
            default: result_d = accum & src_b;
          endcase
        end
      end
    endcase

    zout_d = z_write_d & (result_d == 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q      <= 8'h00;
      accum_write_q <= 1'b0;
      reg_write_q   <= 1'b0;
      z_write_q     <= 1'b0;
      zout_q        <= 1'b0;
      c_write_q     <= 1'b0;
      cout_q        <= 1'b0;
    end else begin
      result_q      <= result_d;
      accum_write_q <= accum_write_d;
      reg_write_q   <= reg_write_d;
      z_write_q     <= z_write_d;
      zout_q        <= zout_d;
      c_write_q     <= c_write_d;
      cout_q        <= cout_d;
    end
  end

  assign result      = result_q;
  assign accum_write = accum_write_q;
  assign reg_write   = reg_write_q;
  assign z_write     = z_write_q;
  assign zout        = zout_q;
  assign c_write     = c_write_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_ez8_alu.sv
// tb_ez8_alu: scoreboard bench for ez8_alu; expected output words are queued as each op is
// driven and compared one clock later. Output word layout:
// {result[7:0], accum_write, reg_write, z_write, zout, c_write, cout}.
module tb_ez8_alu;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic [7:0] regvalue;
  logic [7:0] accum;
  logic [2:0] selector;
  logic       direction;
  logic       cin;
  logic [7:0] result;
  logic       accum_write;
  logic       reg_write;
  logic       z_write;
  logic       zout;
  logic       c_write;
  logic       cout;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks;
  int failures;

  ez8_alu dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .operand     (operand),
    .regvalue    (regvalue),
    .accum       (accum),
    .selector    (selector),
    .direction   (direction),
    .cin         (cin),
    .result      (result),
    .accum_write (accum_write),
    .reg_write   (reg_write),
    .z_write     (z_write),
    .zout        (zout),
    .c_write     (c_write),
    .cout        (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {result, accum_write, reg_write, z_write, zout, c_write, cout};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got res=%02h aw/rw/zw/z/cw/c=%06b, want res=%02h aw/rw/zw/z/cw/c=%06b",
               tag, got[13:6], got[5:0], exp[13:6], exp[5:0]);
    end
  endtask

  task automatic sb_pop_check();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: scoreboard had no expected entry");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs(), e.exp);
    end
  endtask

  // At each falling edge: retire the result of the op driven one cycle earlier, then drive
  // the next op and queue what it must produce after the next rising edge.
  task automatic drive(input string tag, input logic [3:0] op, input logic [2:0] sel,
                       input logic dir, input logic [7:0] opd, input logic [7:0] rv,
                       input logic [7:0] acc, input logic ci, input logic [13:0] exp);
    sb_entry_t e;
    @(negedge clk);
    if (sb_q.size() > 0) sb_pop_check();
    opcode    = op;
    selector  = sel;
    direction = dir;
    operand   = opd;
    regvalue  = rv;
    accum     = acc;
    cin       = ci;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    while (sb_q.size() > 0) sb_pop_check();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    opcode    = 4'b0000;
    selector  = 3'b000;
    direction = 1'b0;
    operand   = 8'h00;
    regvalue  = 8'h00;
    accum     = 8'h00;
    cin       = 1'b0;

    repeat (2) @(posedge clk);
    #1 check("reset_state", obs(), 14'h0000);
    @(negedge clk);
    reset = 1'b0;

    // GET / PUT
    drive("get",  4'b0000, 3'b000, 1'b0, 8'h00, 8'd12, 8'd0,  1'b0, {8'd12, 6'b100000});
    drive("put",  4'b0000, 3'b000, 1'b1, 8'h00, 8'd12, 8'd10, 1'b0, {8'd10, 6'b010000});
    // Shifts
    drive("shl_r",    4'b0001, 3'b000, 1'b0, 8'h00, 8'd4,  8'h02, 1'b0, {8'h20, 6'b101000});
    drive("shl_l",    4'b0101, 3'b000, 1'b0, 8'd3,  8'd4,  8'h02, 1'b0, {8'h10, 6'b101000});
    drive("shr_zero", 4'b0001, 3'b100, 1'b0, 8'h00, 8'd7,  8'h40, 1'b0, {8'h00, 6'b101100});
    drive("shr_l",    4'b0101, 3'b100, 1'b0, 8'd3,  8'd7,  8'h80, 1'b0, {8'h10, 6'b101000});
    drive("sar_r",    4'b0001, 3'b110, 1'b0, 8'h00, 8'd7,  8'h80, 1'b0, {8'hFF, 6'b101000});
    drive("sar_l",    4'b0101, 3'b110, 1'b0, 8'd3,  8'd7,  8'h80, 1'b0, {8'hF0, 6'b101000});
    drive("shl_amt3", 4'b0001, 3'b000, 1'b1, 8'h00, 8'h0B, 8'h01, 1'b0, {8'h08, 6'b011000});
    drive("shl_dflt", 4'b0101, 3'b011, 1'b0, 8'd1,  8'd0,  8'h81, 1'b0, {8'h02, 6'b101000});
    // Arithmetic
    drive("add",   4'b0010, 3'b000, 1'b0, 8'd28, 8'd10, 8'd228, 1'b0, {8'd238, 6'b101010});
    drive("addl",  4'b0110, 3'b000, 1'b0, 8'd28, 8'd10, 8'd228, 1'b0, {8'd0,   6'b101111});
    drive("adc",   4'b0010, 3'b010, 1'b0, 8'd28, 8'd10, 8'd228, 1'b1, {8'd239, 6'b101010});
    drive("adcl",  4'b0110, 3'b010, 1'b0, 8'd28, 8'd10, 8'd228, 1'b1, {8'd1,   6'b101011});
    drive("sub",   4'b0010, 3'b100, 1'b0, 8'd28, 8'd10, 8'd228, 1'b0, {8'd218, 6'b101011});
    drive("subl",  4'b0110, 3'b100, 1'b0, 8'd28, 8'd10, 8'd228, 1'b0, {8'd200, 6'b101011});
    drive("sbc",   4'b0010, 3'b110, 1'b0, 8'd28, 8'd10, 8'd228, 1'b0, {8'd217, 6'b101011});
    drive("sub_bw",4'b0010, 3'b100, 1'b1, 8'd0,  8'd10, 8'd5,   1'b0, {8'd251, 6'b011010});
    drive("add_dflt",4'b0010,3'b111,1'b0, 8'd28, 8'd10, 8'd228, 1'b1, {8'd238, 6'b101010});
    // Logic
    drive("and",   4'b0011, 3'b000, 1'b0, 8'h0C, 8'h03, 8'h05, 1'b0, {8'h01, 6'b101000});
    drive("andl",  4'b0111, 3'b000, 1'b0, 8'h0C, 8'h03, 8'h05, 1'b0, {8'h04, 6'b101000});
    drive("or",    4'b0011, 3'b010, 1'b0, 8'h0C, 8'h03, 8'h05, 1'b0, {8'h07, 6'b101000});
    drive("orl",   4'b0111, 3'b010, 1'b0, 8'h0C, 8'h03, 8'h05, 1'b0, {8'h0D, 6'b101000});
    drive("xor",   4'b0011, 3'b100, 1'b0, 8'h0C, 8'h03, 8'h05, 1'b0, {8'h06, 6'b101000});
    drive("xorl",  4'b0111, 3'b100, 1'b0, 8'h0C, 8'h03, 8'h05, 1'b0, {8'h09, 6'b101000});
    drive("and_z", 4'b0111, 3'b001, 1'b1, 8'h0A, 8'h03, 8'h05, 1'b0, {8'h00, 6'b011100});
    // Misc
    drive("set",   4'b0100, 3'b000, 1'b0, 8'd12, 8'd0,  8'd0,  1'b0, {8'd12, 6'b100000});
    drive("clr",   4'b1111, 3'b000, 1'b0, 8'd0,  8'h55, 8'h33, 1'b0, {8'h00, 6'b101100});
    drive("com",   4'b1111, 3'b100, 1'b1, 8'd0,  8'hAC, 8'h33, 1'b0, {8'h53, 6'b011000});
    drive("undef", 4'b1000, 3'b000, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, {8'h00, 6'b000000});
    drive("undef2",4'b1100, 3'b100, 1'b0, 8'h01, 8'h02, 8'h03, 1'b1, {8'h00, 6'b000000});
    flush();

    // Reset in the middle of operation, then recovery with one-edge latency.
    drive("pre_rst", 4'b0010, 3'b000, 1'b0, 8'd0, 8'd10, 8'd228, 1'b0, {8'd238, 6'b101010});
    @(posedge clk);
    #1 sb_pop_check();
    #2 reset = 1'b1;
    #1 check("rst_async", obs(), 14'h0000);
    @(posedge clk);
    #1 check("rst_hold", obs(), 14'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_rel_wait", obs(), 14'h0000);
    @(posedge clk);
    #1 check("rst_first", obs(), {8'd238, 6'b101010});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ez8_alu.md
Name: ez8_alu

Overview:
- 8-bit ALU for the ez8 processor datapath.
- Takes a decoded 4-bit opcode, a 3-bit function selector and a direction bit. Combines the accumulator with either a register-file value or an instruction literal.
- Produces an 8-bit result plus write enables for the accumulator, the register file and the Z/C status flags.
- All outputs are registered: one clock of latency from inputs to outputs.

Parameters:
- None. Data width is fixed at 8 bits.

Ports:
- clk  in  1  system clock; outputs update on its rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  4  instruction class; bit 2 = literal-source flag for arithmetic, shift and logic classes
- operand  in  8  instruction literal
- regvalue  in  8  value read from the register file
- accum  in  8  current accumulator value
- selector  in  3  function select within an opcode class
- direction  in  1  destination select: 0 = accumulator, 1 = register
- cin  in  1  current carry flag
- result  out  8  computed value
- accum_write  out  1  write result to accumulator
- reg_write  out  1  write result to register file
- z_write  out  1  update Z flag
- zout  out  1  new Z value
- c_write  out  1  update C flag
- cout  out  1  new C value

Behaviour:
- Datapath: a combinational next-state block feeds one register stage for all outputs. No other state.
- Reset: while reset is high, all outputs are 0, asynchronously. The first valid output appears at the first rising clk after reset deasserts.
- Source selection: B = operand when opcode[2]=1, otherwise regvalue. Applies to shift, arithmetic and logic classes.
- Destination: accum_write = ~direction and reg_write = direction. Applies to every defined opcode except 0000 (see GET/PUT) and undefined opcodes.
- Z flag: zout = (result == 0) whenever z_write is 1.
- Default output values: C, Z and cout are 0 wherever not specified below.
- opcode 0000, GET/PUT (no flag writes):
  - direction 0 (GET): result = regvalue, accum_write = 1.
  - direction 1 (PUT): result = accum, reg_write = 1.
- opcode x001, shift (z_write = 1, c_write = 0). The accumulator is shifted by B[2:0] (0 to 7):
  - selector 000: logical left.
  - selector 100: logical right.
  - selector 110: arithmetic right (sign-fill from accum[7]).
  - Other selectors: treated as logical left.
- opcode x010, arithmetic (z_write = 1, c_write = 1). Computed as a 9-bit sum; result = sum[7:0], cout = sum[8]:
  - selector 000 ADD: accum + B.
  - selector 010 ADC: accum + B + cin.
  - selector 100 SUB: accum + ~B + 1. cout = 1 means no borrow.
  - selector 110 SBC: accum + ~B + cin.
  - Other selectors: treated as ADD.
- opcode x011, logic (z_write = 1, c_write = 0):
  - selector 000: AND.
  - selector 010: OR.
  - selector 100: XOR.
  - Other selectors: AND.
- opcode 0100, SET: result = operand. No flag writes.
- opcode 1111 (z_write = 1, c_write = 0):
  - selector 000 CLR: result = 0.
  - selector 100 COM: result = ~regvalue.
  - Other selectors: CLR.
- All other opcodes: result = 0, all write enables 0 (no-op).
- Inputs are sampled only at clk edges. Changing inputs between edges has no output effect.

Test Plan:
- GET/PUT: opcode=0000, regvalue=12, dir=0 -> result 12, accum_write=1, no other writes. Then dir=1, accum=10 -> result 10, reg_write=1 only.
- Shifts:
  - accum=0x02, regvalue=4, opcode 0001/sel 000 -> 0x20, z_write=1, zout=0, c_write=0.
  - Same with opcode 0101, operand=3 -> 0x10.
  - accum=0x40, sel 100, regvalue=7 -> 0, zout=1.
  - accum=0x80, opcode 0101/sel 100, operand=3 -> 0x10.
  - accum=0x80, opcode 0001/sel 110, regvalue=7 -> 0xFF.
  - accum=0x80, opcode 0101/sel 110, operand=3 -> 0xF0.
- Arithmetic, accum=228, regvalue=10, operand=28:
  - ADD -> 238, cout 0.
  - ADDL -> 0, zout 1, cout 1.
  - ADC with cin=1 -> 239; ADCL with cin=1 -> 1, cout 1.
  - SUB -> 218; SUBL -> 200.
- Logic, accum=0x05, regvalue=0x03, operand=0x0C:
  - AND -> 0x01; ANDL -> 0x04.
  - OR -> 0x07; ORL -> 0x0D.
  - XOR -> 0x06; XORL -> 0x09.
- Misc:
  - SET with operand=12 -> 12.
  - CLR -> 0, zout=1.
  - COM with regvalue=0xAC, dir=1 -> 0x53, reg_write=1.
- Reset/latency: assert reset mid-operation -> all outputs 0 immediately. After release, outputs reflect inputs exactly one clk edge later.
